// File: rtl/alu_exec_seq_pkg.sv
// Shared types, widths and ALU control codes for the EX-stage execute unit.
// Control code values mirror the alu_control decoder output.
package alu_exec_seq_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_ADD        = 4'd0;
  localparam logic [3:0] ALU_SUB        = 4'd1;
  localparam logic [3:0] ALU_SLL        = 4'd2;
  localparam logic [3:0] ALU_SLT        = 4'd3;
  localparam logic [3:0] ALU_SLTU       = 4'd4;
  localparam logic [3:0] ALU_XOR        = 4'd5;
  localparam logic [3:0] ALU_SRL        = 4'd6;
  localparam logic [3:0] ALU_SRA        = 4'd7;
  localparam logic [3:0] ALU_OR         = 4'd8;
  localparam logic [3:0] ALU_AND        = 4'd9;
  localparam logic [3:0] ALU_NOTEQ      = 4'd10;
  localparam logic [3:0] ALU_SGE        = 4'd11;
  localparam logic [3:0] ALU_SGEU       = 4'd12;
  localparam logic [3:0] ALU_JUMP       = 4'd13;
  localparam logic [3:0] ALU_MATRIX_MUL = 4'd14;
  localparam logic [3:0] ALU_INVALID    = 4'd15;

  function automatic logic is_shift(
    input logic [3:0] c
  );
    return (c == ALU_SLL) || (c == ALU_SRL) ||
           (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_seq_if.sv
// Request/response handshake bundle between EX issue logic
// and the sequential execute unit.
interface alu_exec_seq_if;
  import alu_exec_seq_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            br_taken;
  logic            illegal;

  modport master (
    output in_valid, alu_ctrl, op1, op2,
    output flush, out_ready,
    input  in_ready, out_valid, result,
    input  br_taken, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, op1, op2,
    input  flush, out_ready,
    output in_ready, out_valid, result,
    output br_taken, illegal
  );

endinterface

// File: rtl/alu_exec_seq_mac.sv
// One element of a 2x2 packed-byte matrix product:
// y = (a0*b0 + a1*b1) mod 256.
module mat2_elem_mac (
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  output logic [7:0] y
);

  assign y = a0 * b0 + a1 * b1;

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential execute unit: 1-cycle ALU ops, bit-serial shifts
// and a 4-cycle packed-byte 2x2 matrix multiply.
module alu_exec_seq
  import alu_exec_seq_pkg::*;
(
  input logic           clk,
  input logic           rst,
  alu_exec_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    MATMUL = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_n;

  logic [XLEN-1:0]    acc, acc_n;
  logic [XLEN-1:0]    opb, opb_n;
  logic [XLEN-1:0]    res, res_n;
  logic [SHAMT_W-1:0] cnt, cnt_n;
  logic [1:0]         idx, idx_n;
  logic [3:0]         ctrl, ctrl_n;
  logic               br, br_n;
  logic               ill, ill_n;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    s_res;
  logic               s_br;
  logic               s_ill;
  logic               eq, lt, ltu;
  logic [XLEN-1:0]    sh;
  logic [7:0]         a0, a1, b0, b1, mac_y;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res;
  assign bus.br_taken  = br;
  assign bus.illegal   = ill;

  assign shamt = bus.op2[SHAMT_W-1:0];
  assign eq    = (bus.op1 == bus.op2);
  assign lt    = $signed(bus.op1) < $signed(bus.op2);
  assign ltu   = bus.op1 < bus.op2;

  always_comb begin
    s_res = '0;
    s_br  = 1'b0;
    s_ill = 1'b0;
    case (bus.alu_ctrl)
      ALU_ADD:  s_res = bus.op1 + bus.op2;
      ALU_SUB: begin
        s_res = bus.op1 - bus.op2;
        s_br  = eq;
      end
      ALU_SLL, ALU_SRL, ALU_SRA:
        s_res = bus.op1;
      ALU_SLT: begin
        s_res = {{(XLEN-1){1'b0}}, lt};
        s_br  = lt;
      end
      ALU_SLTU: begin
        s_res = {{(XLEN-1){1'b0}}, ltu};
        s_br  = ltu;
      end
      ALU_SGE: begin
        s_res = {{(XLEN-1){1'b0}}, !lt};
        s_br  = !lt;
      end
      ALU_SGEU: begin
        s_res = {{(XLEN-1){1'b0}}, !ltu};
        s_br  = !ltu;
      end
      ALU_XOR:   s_res = bus.op1 ^ bus.op2;
      ALU_OR:    s_res = bus.op1 | bus.op2;
      ALU_AND:   s_res = bus.op1 & bus.op2;
      ALU_NOTEQ: s_br  = !eq;
      ALU_JUMP: begin
        s_res = bus.op1 + 32'd4;
        s_br  = 1'b1;
      end
      default:   s_ill = 1'b1;
    endcase
  end

  always_comb begin
    sh = acc >> 1;
    if (ctrl == ALU_SLL)
      sh = acc << 1;
    else if (ctrl == ALU_SRA)
      sh = {acc[XLEN-1], acc[XLEN-1:1]};
  end

  // Row i of A is selected by idx[1], column j of B by idx[0].
  assign a0 = idx[1] ? acc[23:16] : acc[7:0];
  assign a1 = idx[1] ? acc[31:24] : acc[15:8];
  assign b0 = idx[0] ? opb[15:8]  : opb[7:0];
  assign b1 = idx[0] ? opb[31:24] : opb[23:16];

  mat2_elem_mac u_mac (
    .a0 (a0),
    .a1 (a1),
    .b0 (b0),
    .b1 (b1),
    .y  (mac_y)
  );

  always_comb begin
    state_n = state;
    acc_n   = acc;
    opb_n   = opb;
    res_n   = res;
    cnt_n   = cnt;
    idx_n   = idx;
    ctrl_n  = ctrl;
    br_n    = br;
    ill_n   = ill;
    if (bus.flush) begin
      state_n = IDLE;
      if (state != IDLE) begin
        res_n = '0;
        br_n  = 1'b0;
        ill_n = 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          ctrl_n = bus.alu_ctrl;
          unique case (1'b1)
            is_shift(bus.alu_ctrl) && (shamt != '0): begin
              acc_n   = bus.op1;
              cnt_n   = shamt;
              br_n    = 1'b0;
              ill_n   = 1'b0;
              state_n = SHIFT;
            end
            bus.alu_ctrl == ALU_MATRIX_MUL: begin
              acc_n   = bus.op1;
              opb_n   = bus.op2;
              idx_n   = 2'd0;
              res_n   = '0;
              br_n    = 1'b0;
              ill_n   = 1'b0;
              state_n = MATMUL;
            end
            default: begin
              res_n   = s_res;
              br_n    = s_br;
              ill_n   = s_ill;
              state_n = DONE;
            end
          endcase
        end
        SHIFT: begin
          acc_n = sh;
          cnt_n = cnt - 1'b1;
          if (cnt == 5'd1) begin
            res_n   = sh;
            state_n = DONE;
          end
        end
        MATMUL: begin
          unique case (idx)
            2'd0: res_n[7:0]   = mac_y;
            2'd1: res_n[15:8]  = mac_y;
            2'd2: res_n[23:16] = mac_y;
            2'd3: res_n[31:24] = mac_y;
          endcase
          idx_n = idx + 2'd1;
          if (idx == 2'd3)
            state_n = DONE;
        end
        DONE: if (bus.out_ready)
          state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      opb   <= '0;
      res   <= '0;
      cnt   <= '0;
      idx   <= '0;
      ctrl  <= '0;
      br    <= 1'b0;
      ill   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      opb   <= opb_n;
      res   <= res_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      ctrl  <= ctrl_n;
      br    <= br_n;
      ill   <= ill_n;
    end
  end

endmodule
